// File: rtl/mem_capture_pkg.sv
// mem_capture_pkg: shared state encoding and ready-sampling mode constants for the read capture block
package mem_capture_pkg;
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_DONE = 2'd2,
      ST_TOUT = 2'd3
   } state_t;
   localparam bit MODE_LEVEL = 1'b0;
   localparam bit MODE_EDGE  = 1'b1;
endpackage

// File: rtl/mem_read_capture_if.sv
// mem_read_capture_if: read strobe/data handshake between a host-side source and the capture block
interface mem_read_capture_if #(
   parameter int DATA_W = 8,
   parameter int CNT_W  = 4
);
   logic              mem_read;
   logic              data_ready;
   logic [DATA_W-1:0] data_bus;
   logic [CNT_W-1:0]  burst_len;
   logic [DATA_W-1:0] data;
   logic              data_valid;
   logic [CNT_W-1:0]  word_cnt;
   logic              busy;
   logic              done;
   logic              timeout_err;
   modport master (
      output mem_read, data_ready, data_bus, burst_len,
      input  data, data_valid, word_cnt, busy, done, timeout_err
   );
   modport slave (
      input  mem_read, data_ready, data_bus, burst_len,
      output data, data_valid, word_cnt, busy, done, timeout_err
   );
endinterface

// File: rtl/rdy_edge_det.sv
// rdy_edge_det: registered copy of a ready strobe and its 0->1 rise indication
module rdy_edge_det (
   input  logic clk,
   input  logic rst,
   input  logic rdy,
   output logic rise
);
   logic rdy_q, rdy_d;
   always_comb rdy_d = rdy;
   always_ff @(posedge clk) begin
      if (rst) rdy_q <= 1'b0;
      else     rdy_q <= rdy_d;
   end
   assign rise = rdy & ~rdy_q;
endmodule

// File: rtl/mem_read_capture.sv
// mem_read_capture: waits for data_ready while mem_read is high and registers data_bus, with burst count and timeout
module mem_read_capture
   import mem_capture_pkg::*;
#(
   parameter int DATA_W    = 8,
   parameter int CNT_W     = 4,
   parameter bit EDGE_MODE = MODE_LEVEL,
   parameter int TIMEOUT   = 64,
   parameter int TMR_W     = 8
) (
   input logic clk,
   input logic rst,
   mem_read_capture_if.slave bus
);
   state_t state_q, state_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic data_valid_q, data_valid_d;
   logic [CNT_W-1:0] word_cnt_q, word_cnt_d, len_q, len_d;
   logic [TMR_W-1:0] timer_q, timer_d;
   logic rise, cap, take, last_word, expired;
   rdy_edge_det u_rdy (.clk(clk), .rst(rst), .rdy(bus.data_ready), .rise(rise));
   assign cap       = bus.mem_read & (EDGE_MODE == MODE_EDGE ? rise : bus.data_ready);
   assign take      = state_q == ST_WAIT && cap;
   assign last_word = len_q != '0 && word_cnt_q + CNT_W'(1) == len_q;
   assign expired   = TIMEOUT != 0 && timer_q == TMR_W'(TIMEOUT - 1);
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         data_q       <= '0;
         data_valid_q <= 1'b0;
         word_cnt_q   <= '0;
         len_q        <= '0;
         timer_q      <= '0;
      end else begin
         state_q      <= state_d;
         data_q       <= data_d;
         data_valid_q <= data_valid_d;
         word_cnt_q   <= word_cnt_d;
         len_q        <= len_d;
         timer_q      <= timer_d;
      end
   end
   // dropping mem_read returns to IDLE from any state; a capture beats an expiring timer
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: state_d = bus.mem_read ? ST_WAIT : ST_IDLE;
         ST_WAIT: state_d = !bus.mem_read ? ST_IDLE
                          : cap           ? (last_word ? ST_DONE : ST_WAIT)
                          : expired       ? ST_TOUT : ST_WAIT;
         default: state_d = bus.mem_read ? state_q : ST_IDLE;
      endcase
   end
   always_comb begin
      data_d       = !bus.mem_read ? '0 : take ? bus.data_bus : data_q;
      data_valid_d = take;
      word_cnt_d   = !bus.mem_read ? '0 : take ? word_cnt_q + CNT_W'(1) : word_cnt_q;
      len_d        = state_q == ST_IDLE ? bus.burst_len : len_q;
      timer_d      = (state_q == ST_WAIT && bus.mem_read && !cap) ? timer_q + TMR_W'(1) : '0;
   end
   assign bus.data        = data_q;
   assign bus.data_valid  = data_valid_q;
   assign bus.word_cnt    = word_cnt_q;
   assign bus.busy        = state_q == ST_WAIT;
   assign bus.done        = state_q == ST_DONE;
   assign bus.timeout_err = state_q == ST_TOUT;
endmodule
